cond_logic_it: RTL and testbench

Parametrised condition unit for the single-cycle ARM datapath. It generates PCSrc, RegWrite and MemWrite from the instruction condition and the NZCV flag register. It adds Thumb-2 style IT-block sequencing: an ITSTATE register supplies per-slot conditions for up to IT_MAX following instructions. It sits between the decoder and the register file, memory and PC mux, and owns the architectural flag register.

---
 rtl/cond_logic_it.sv | 123 ++++++++++++
 tb/tb_cond_logic_it.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_logic_it.sv
// ARM condition unit: gates PC/register/memory writes by the condition field and NZCV, and owns the flag register.
// Adds IT-block sequencing: an ITSTATE register supplies the condition for up to IT_MAX following instructions.
module cond_logic_it #(
    parameter int IT_MAX = 4,
    parameter bit IT_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       NoWrite,
    input  logic       MemW,
    input  logic [1:0] FlagW,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic       ITStart,
    input  logic [3:0] ITFirstCond,
    input  logic [3:0] ITMask,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags,
    output logic       InIT,
    output logic       ITFault
);

    localparam logic [2:0] LMAX = 3'(IT_MAX);

    logic [3:0] r_flags;
    logic [7:0] r_itstate;
    logic       r_init;

    logic       w_itstart;
    logic       w_init;
    logic [3:0] w_effcond;
    logic       w_condex;
    logic       w_g;
    logic [2:0] w_itlen;
    logic       w_len_ok;
    logic       w_accept;
    logic [4:0] w_shift;
    logic       w_n, w_z, w_c, w_v;

    assign w_itstart = IT_EN & ITStart;
    assign w_init    = IT_EN & r_init;
    assign w_effcond = w_init ? r_itstate[7:4] : Cond;
    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        w_condex = 1'b0;
        case (w_effcond)
            4'h0: w_condex = w_z;
            4'h1: w_condex = ~w_z;
            4'h2: w_condex = w_c;
            4'h3: w_condex = ~w_c;
            4'h4: w_condex = w_n;
            4'h5: w_condex = ~w_n;
            4'h6: w_condex = w_v;
            4'h7: w_condex = ~w_v;
            4'h8: w_condex = w_c & ~w_z;
            4'h9: w_condex = ~w_c | w_z;
            4'hA: w_condex = (w_n == w_v);
            4'hB: w_condex = (w_n != w_v);
            4'hC: w_condex = ~w_z & (w_n == w_v);
            4'hD: w_condex = w_z | (w_n != w_v);
            4'hE: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    // An IT instruction never writes anything itself.
    assign w_g      = en & w_condex & ~w_itstart;
    assign PCSrc    = w_g & PCS;
    assign RegWrite = w_g & RegW & ~NoWrite;
    assign MemWrite = w_g & MemW;

    // Block length is set by the position of the terminating 1 in the mask.
    always_comb begin
        w_itlen = 3'd0;
        casez (ITMask)
            4'b???1: w_itlen = 3'd4;
            4'b??10: w_itlen = 3'd3;
            4'b?100: w_itlen = 3'd2;
            4'b1000: w_itlen = 3'd1;
            default: w_itlen = 3'd0;
        endcase
    end

    assign w_len_ok = (w_itlen != 3'd0) && (w_itlen <= LMAX);
    assign w_accept = en & w_itstart & ~w_init & w_len_ok;
    assign w_shift  = {r_itstate[3:0], 1'b0};

    assign ITFault = (en & w_itstart & (w_init | ~w_len_ok))
                   | (en & PCS & w_init & (r_itstate[2:0] != 3'b000));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags   <= 4'h0;
            r_itstate <= 8'h00;
            r_init    <= 1'b0;
        end else if (en) begin
            if (w_g && FlagW[1]) r_flags[3:2] <= ALUFlags[3:2];
            if (w_g && FlagW[0]) r_flags[1:0] <= ALUFlags[1:0];
            if (w_init) begin
                // A taken branch or an exhausted mask ends the block.
                if (PCSrc || (w_shift[3:0] == 4'b0000)) begin
                    r_itstate <= 8'h00;
                    r_init    <= 1'b0;
                end else begin
                    r_itstate[4:0] <= w_shift;
                end
            end else if (w_accept) begin
                r_itstate <= {ITFirstCond, ITMask};
                r_init    <= 1'b1;
            end
        end
    end

    assign Flags = r_flags;
    assign InIT  = w_init;

endmodule

// File: tb/tb_cond_logic_it.sv
// Bench for cond_logic_it: directed vector table, async-reset sequence, then random stimulus vs a slot-queue model.
// Instance a uses IT_MAX=4, instance b uses IT_MAX=2.
module tb_cond_logic_it;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, pcs, regw, nowrite, memw, its;
    logic [1:0] flagw;
    logic [3:0] cond, aluf, fc, mask;

    logic       a_pc, a_rw, a_mw, a_init, a_flt;
    logic [3:0] a_flags;
    logic       b_pc, b_rw, b_mw, b_init, b_flt;
    logic [3:0] b_flags;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cond_logic_it #(.IT_MAX(4), .IT_EN(1'b1)) dut_a (
        .clk(clk), .reset(reset), .en(en), .PCS(pcs), .RegW(regw), .NoWrite(nowrite),
        .MemW(memw), .FlagW(flagw), .Cond(cond), .ALUFlags(aluf), .ITStart(its),
        .ITFirstCond(fc), .ITMask(mask), .PCSrc(a_pc), .RegWrite(a_rw), .MemWrite(a_mw),
        .Flags(a_flags), .InIT(a_init), .ITFault(a_flt)
    );

    cond_logic_it #(.IT_MAX(2), .IT_EN(1'b1)) dut_b (
        .clk(clk), .reset(reset), .en(en), .PCS(pcs), .RegW(regw), .NoWrite(nowrite),
        .MemW(memw), .FlagW(flagw), .Cond(cond), .ALUFlags(aluf), .ITStart(its),
        .ITFirstCond(fc), .ITMask(mask), .PCSrc(b_pc), .RegWrite(b_rw), .MemWrite(b_mw),
        .Flags(b_flags), .InIT(b_init), .ITFault(b_flt)
    );

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model: per-instance queue of pending slot conditions
    logic [3:0] m_flags [2];
    logic [3:0] m_slot  [2][4];
    int         m_cnt   [2];
    int         m_max   [2];

    function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;          4'h1: return !z;
            4'h2: return cy;         4'h3: return !cy;
            4'h4: return n;          4'h5: return !n;
            4'h6: return v;          4'h7: return !v;
            4'h8: return cy && !z;   4'h9: return !cy || z;
            4'hA: return n == v;     4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int it_len(input logic [3:0] m);
        for (int k = 0; k < 4; k++)
            if (m[k]) return 4 - k;
        return 0;
    endfunction

    function automatic logic m_gate(input int i);
        logic [3:0] ec;
        ec = (m_cnt[i] > 0) ? m_slot[i][0] : cond;
        return en && cond_true(ec, m_flags[i]) && !its;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_flags[i] = 4'h0;
            m_cnt[i]   = 0;
        end
    endtask

    task automatic model_check(input int i, input string tag);
        logic g, fl;
        int   len;
        logic [3:0] ap, ar, am, af, ai, afl;
        g   = m_gate(i);
        len = it_len(mask);
        fl  = en && ((its && (m_cnt[i] > 0)) || (its && (len == 0 || len > m_max[i]))
                     || (pcs && m_cnt[i] > 1));
        ap  = {3'b0, (i == 0) ? a_pc   : b_pc};
        ar  = {3'b0, (i == 0) ? a_rw   : b_rw};
        am  = {3'b0, (i == 0) ? a_mw   : b_mw};
        ai  = {3'b0, (i == 0) ? a_init : b_init};
        afl = {3'b0, (i == 0) ? a_flt  : b_flt};
        af  = (i == 0) ? a_flags : b_flags;
        chk({tag, ".pcsrc"},    ap,  {3'b0, g && pcs});
        chk({tag, ".regwrite"}, ar,  {3'b0, g && regw && !nowrite});
        chk({tag, ".memwrite"}, am,  {3'b0, g && memw});
        chk({tag, ".flags"},    af,  m_flags[i]);
        chk({tag, ".init"},     ai,  {3'b0, m_cnt[i] > 0});
        chk({tag, ".itfault"},  afl, {3'b0, fl});
    endtask

    task automatic model_step(input int i);
        logic g;
        int   len;
        g   = m_gate(i);
        len = it_len(mask);
        if (en) begin
            if (g && flagw[1]) m_flags[i][3:2] = aluf[3:2];
            if (g && flagw[0]) m_flags[i][1:0] = aluf[1:0];
            if (m_cnt[i] > 0) begin
                if (g && pcs) m_cnt[i] = 0;
                else begin
                    for (int k = 0; k < 3; k++) m_slot[i][k] = m_slot[i][k+1];
                    m_cnt[i]--;
                end
            end else if (its && len > 0 && len <= m_max[i]) begin
                m_slot[i][0] = fc;
                for (int k = 1; k < len; k++) m_slot[i][k] = {fc[3:1], mask[4-k]};
                m_cnt[i] = len;
            end
        end
    endtask

    // ---------------- directed vector table
    typedef struct {
        logic       en, pcs, regw, nw, memw;
        logic [1:0] flagw;
        logic [3:0] cond, alu;
        logic       its;
        logic [3:0] fc, mask;
        logic       x_pc, x_rw, x_mw, x_flt;
        logic [3:0] x_flags;
        logic       x_init, x_flt_b, x_init_b;
    } vec_t;

    function automatic vec_t mkv(input int e, p, r, nw, mw, fw, c, al, it, f, m,
                                 input int xp, xr, xm, xf, xfl, xi, xfb, xib);
        vec_t v;
        v.en = e[0]; v.pcs = p[0]; v.regw = r[0]; v.nw = nw[0]; v.memw = mw[0];
        v.flagw = fw[1:0]; v.cond = c[3:0]; v.alu = al[3:0]; v.its = it[0];
        v.fc = f[3:0]; v.mask = m[3:0];
        v.x_pc = xp[0]; v.x_rw = xr[0]; v.x_mw = xm[0]; v.x_flt = xf[0];
        v.x_flags = xfl[3:0]; v.x_init = xi[0]; v.x_flt_b = xfb[0]; v.x_init_b = xib[0];
        return v;
    endfunction

    task automatic idle_inputs();
        en = 1'b0; pcs = 1'b0; regw = 1'b0; nowrite = 1'b0; memw = 1'b0; its = 1'b0;
        flagw = 2'b00; cond = 4'hE; aluf = 4'h0; fc = 4'h0; mask = 4'h0;
    endtask

    vec_t vt[$];

    initial begin
        //        en pc rw nw mw fw cond alu it fc  mask | pc rw mw flt flags init fltb initb
        vt.push_back(mkv(1,0,1,0,0,3,'hE,'h4,0,'h0,'h0, 0,1,0,0,'h0,0,0,0)); // SUBS -> Z
        vt.push_back(mkv(1,0,1,0,0,0,'h0,'h0,0,'h0,'h0, 0,1,0,0,'h4,0,0,0)); // EQ sees new Z
        vt.push_back(mkv(1,0,0,0,0,0,'hE,'h0,0,'h0,'h0, 0,0,0,0,'h4,0,0,0)); // FlagW=00 keeps
        vt.push_back(mkv(1,1,1,0,1,3,'hF,'hF,0,'h0,'h0, 0,0,0,0,'h4,0,0,0)); // NV
        vt.push_back(mkv(1,0,1,1,0,0,'hE,'h0,0,'h0,'h0, 0,0,0,0,'h4,0,0,0)); // NoWrite
        vt.push_back(mkv(1,0,1,0,1,0,'hF,'h0,1,'h0,'hC, 0,0,0,0,'h4,0,0,0)); // ITE EQ
        vt.push_back(mkv(1,0,1,0,0,0,'hF,'h0,0,'h0,'h0, 0,1,0,0,'h4,1,0,1)); // slot EQ
        vt.push_back(mkv(1,0,1,0,0,0,'hF,'h0,0,'h0,'h0, 0,0,0,0,'h4,1,0,1)); // slot NE
        vt.push_back(mkv(1,0,0,0,0,0,'hE,'h0,0,'h0,'h0, 0,0,0,0,'h4,0,0,0));
        vt.push_back(mkv(1,0,0,0,0,0,'hE,'h0,1,'h0,'h1, 0,0,0,0,'h4,0,1,0)); // ITTTT EQ
        vt.push_back(mkv(1,0,1,0,0,0,'hF,'h0,0,'h0,'h0, 0,1,0,0,'h4,1,0,0));
        vt.push_back(mkv(1,0,0,0,1,0,'hF,'h0,0,'h0,'h0, 0,0,1,0,'h4,1,0,0));
        vt.push_back(mkv(0,0,1,0,1,3,'hF,'hF,0,'h0,'h0, 0,0,0,0,'h4,1,0,0)); // bubble
        vt.push_back(mkv(1,0,1,0,0,0,'hF,'h0,0,'h0,'h0, 0,1,0,0,'h4,1,0,0));
        vt.push_back(mkv(1,0,1,0,0,0,'hF,'h0,0,'h0,'h0, 0,1,0,0,'h4,1,0,0));
        vt.push_back(mkv(1,0,1,0,0,0,'hF,'h0,0,'h0,'h0, 0,0,0,0,'h4,0,0,0)); // block over
        vt.push_back(mkv(1,0,0,0,0,0,'hE,'h0,1,'hE,'h2, 0,0,0,0,'h4,0,1,0)); // ITTT AL
        vt.push_back(mkv(1,1,0,0,0,0,'h0,'h0,0,'h0,'h0, 1,0,0,1,'h4,1,0,0)); // branch slot 1/3
        vt.push_back(mkv(1,0,1,0,0,0,'hE,'h0,0,'h0,'h0, 0,1,0,0,'h4,0,0,0)); // block cleared
        vt.push_back(mkv(1,0,0,0,0,0,'hE,'h0,1,'h0,'h2, 0,0,0,0,'h4,0,1,0)); // ITTT EQ
        vt.push_back(mkv(1,0,1,0,0,0,'hF,'h0,1,'h0,'h8, 0,0,0,1,'h4,1,0,0)); // nested IT
        vt.push_back(mkv(1,0,1,0,0,0,'hF,'h0,0,'h0,'h0, 0,1,0,0,'h4,1,0,1));
        vt.push_back(mkv(1,0,1,0,0,0,'hF,'h0,0,'h0,'h0, 0,1,0,0,'h4,1,0,0));
        vt.push_back(mkv(1,0,1,0,0,0,'hF,'h0,0,'h0,'h0, 0,0,0,0,'h4,0,0,0));
        vt.push_back(mkv(1,0,0,0,0,0,'hE,'h0,1,'h0,'h0, 0,0,0,1,'h4,0,1,0)); // empty mask
        vt.push_back(mkv(1,0,1,0,0,0,'hF,'h0,0,'h0,'h0, 0,0,0,0,'h4,0,0,0));

        m_max[0] = 4;
        m_max[1] = 2;
        idle_inputs();
        reset = 1'b1;
        #12;
        chk("reset.flags", a_flags, 4'h0);
        chk("reset.init",  {3'b0, a_init}, 4'h0);
        chk("reset.regwrite", {3'b0, a_rw}, 4'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vt[i]) begin
            @(negedge clk);
            en = vt[i].en; pcs = vt[i].pcs; regw = vt[i].regw; nowrite = vt[i].nw;
            memw = vt[i].memw; flagw = vt[i].flagw; cond = vt[i].cond; aluf = vt[i].alu;
            its = vt[i].its; fc = vt[i].fc; mask = vt[i].mask;
            #1;
            chk($sformatf("v%0d.pcsrc", i),    {3'b0, a_pc},   {3'b0, vt[i].x_pc});
            chk($sformatf("v%0d.regwrite", i), {3'b0, a_rw},   {3'b0, vt[i].x_rw});
            chk($sformatf("v%0d.memwrite", i), {3'b0, a_mw},   {3'b0, vt[i].x_mw});
            chk($sformatf("v%0d.itfault", i),  {3'b0, a_flt},  {3'b0, vt[i].x_flt});
            chk($sformatf("v%0d.flags", i),    a_flags,        vt[i].x_flags);
            chk($sformatf("v%0d.init", i),     {3'b0, a_init}, {3'b0, vt[i].x_init});
            chk($sformatf("v%0d.b_itfault", i), {3'b0, b_flt}, {3'b0, vt[i].x_flt_b});
            chk($sformatf("v%0d.b_init", i),   {3'b0, b_init}, {3'b0, vt[i].x_init_b});
        end

        // Asynchronous reset in the middle of an IT block with all flags set.
        @(negedge clk);
        idle_inputs();
        en = 1'b1; flagw = 2'b11; aluf = 4'hF;
        @(negedge clk);
        flagw = 2'b00; its = 1'b1; fc = 4'hE; mask = 4'h1;
        @(negedge clk);
        its = 1'b0; regw = 1'b1;
        #1;
        chk("rst_mid.pre_flags", a_flags, 4'hF);
        chk("rst_mid.pre_init", {3'b0, a_init}, 4'h1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid.flags", a_flags, 4'h0);
        chk("rst_mid.init", {3'b0, a_init}, 4'h0);
        chk("rst_mid.b_flags", b_flags, 4'h0);
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        model_reset();

        // Random stimulus against the model.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            en      = ($urandom_range(0, 9) != 0);
            pcs     = ($urandom_range(0, 5) == 0);
            regw    = $urandom_range(0, 1) == 1;
            nowrite = ($urandom_range(0, 4) == 0);
            memw    = $urandom_range(0, 1) == 1;
            flagw   = 2'($urandom_range(0, 3));
            cond    = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            aluf    = 4'($urandom_range(0, 15));
            its     = ($urandom_range(0, 5) == 0);
            fc      = 4'($urandom_range(0, 14));
            mask    = 4'($urandom_range(0, 15));
            #1;
            model_check(0, $sformatf("r%0d.a", n));
            model_check(1, $sformatf("r%0d.b", n));
            model_step(0);
            model_step(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
